// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the registered round-robin/fixed channel mux
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin picker: first requester searching upward from ptr+1, wrapping
module rr_arb #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt,
    output logic              gnt_valid
);

    logic [SEL_W-1:0] cand;

    // Scan farthest-first so the nearest requester after ptr is the last to win.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = SEL_W'((int'(ptr) + k) % NUM_CH);
            if (req[cand]) begin
                gnt       = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_reg.sv
// rtl/mux_rr_reg.sv - N:1 mux with fixed/round-robin select and a one-word output register; MUX_RR_REG_CNT_EN adds a transfer counter
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] x,
    input  logic [NUM_CH-1:0]        x_valid,
    output logic [NUM_CH-1:0]        x_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    output logic [DATA_W-1:0]        m,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [SEL_W-1:0]         m_ch
`ifdef MUX_RR_REG_CNT_EN
    ,
    output logic [15:0]              cnt
`endif
);

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  rr_gnt;
    logic              rr_valid;
    logic [SEL_W-1:0]  fix_gnt;
    logic              fix_valid;
    logic [SEL_W-1:0]  gnt;
    logic              gnt_valid;
    logic [DATA_W-1:0] gnt_data;
    logic              load_en;

    rr_arb #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arb (
        .req       (x_valid),
        .ptr       (ptr),
        .gnt       (rr_gnt),
        .gnt_valid (rr_valid)
    );

    // An out-of-range sel matches no channel, so it simply yields no grant.
    always_comb begin
        fix_gnt   = '0;
        fix_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && x_valid[i]) begin
                fix_gnt   = SEL_W'(i);
                fix_valid = 1'b1;
            end
        end
    end

    assign gnt       = (mode == MODE_RR) ? rr_gnt   : fix_gnt;
    assign gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    assign load_en   = !rst && (!m_valid || m_ready);

    always_comb begin
        gnt_data = '0;
        x_ready  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data   = x[i*DATA_W +: DATA_W];
                x_ready[i] = load_en && gnt_valid;
            end
        end
    end

    // ptr resets to the last channel so the first search begins at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m       <= '0;
            m_ch    <= '0;
            ptr     <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            m_valid <= gnt_valid;
            if (gnt_valid) begin
                m    <= gnt_data;
                m_ch <= gnt;
                ptr  <= gnt;
            end
        end
    end

`ifdef MUX_RR_REG_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (m_valid && m_ready) begin
            cnt <= cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb/tb_mux_rr_reg.sv - self-checking bench for mux_rr_reg with a reference model and directed vectors
module tb_mux_rr_reg;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] x;
    logic [NUM_CH-1:0]        x_valid;
    logic [NUM_CH-1:0]        x_ready;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic [DATA_W-1:0]        m;
    logic                     m_valid;
    logic                     m_ready;
    logic [SEL_W-1:0]         m_ch;
`ifdef MUX_RR_REG_CNT_EN
    logic [15:0]              cnt;
`endif

    always #5 clk = ~clk;

    mux_rr_reg #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .sel     (sel),
        .mode    (mode),
        .m       (m),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ch    (m_ch)
`ifdef MUX_RR_REG_CNT_EN
        ,
        .cnt     (cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one slot, last-granted pointer, transfer count.
    bit          mdl_valid;
    logic [7:0]  mdl_m;
    int          mdl_ch;
    int          mdl_ptr;
    int          mdl_cnt;

    function automatic int exp_grant();
        if (rst) return -1;
        if (mdl_valid && !m_ready) return -1;
        if (mode == 1'b0) begin
            if (int'(sel) < NUM_CH && x_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 1; k <= NUM_CH; k++) begin
            if (x_valid[(mdl_ptr + k) % NUM_CH]) return (mdl_ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_valid = 0;
            mdl_m     = 8'h00;
            mdl_ch    = 0;
            mdl_ptr   = NUM_CH - 1;
            mdl_cnt   = 0;
        end else begin
            int g;
            g = exp_grant();
            if (mdl_valid && m_ready) mdl_cnt = (mdl_cnt + 1) % 65536;
            if (!mdl_valid || m_ready) begin
                mdl_valid = (g >= 0);
                if (g >= 0) begin
                    mdl_m   = x[g*DATA_W +: DATA_W];
                    mdl_ch  = g;
                    mdl_ptr = g;
                end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = exp_grant();
        chk("x_ready_model", 32'(x_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("m_valid_model", 32'(m_valid), 32'(mdl_valid));
        if (mdl_valid || rst) begin
            chk("m_model", 32'(m), 32'(mdl_m));
            chk("m_ch_model", 32'(m_ch), 32'(mdl_ch));
        end
`ifdef MUX_RR_REG_CNT_EN
        chk("cnt_model", 32'(cnt), 32'(mdl_cnt));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst     = 1'b1;
        mode    = 1'b0;
        sel     = '0;
        x_valid = '0;
        x       = '0;
        m_ready = 1'b0;
        #3;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m", 32'(m), 32'd0);
        chk("rst_m_ch", 32'(m_ch), 32'd0);
        mode    = 1'b1;
        x_valid = 4'b1111;
        m_ready = 1'b1;
        x       = {8'h43, 8'h32, 8'h21, 8'h10};
        #1;
        chk("rst_x_ready", 32'(x_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 32'(x_ready), 32'b0001);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_seq_ch", 32'(m_ch), 32'(rr_seq[i]));
            chk("rr_seq_valid", 32'(m_valid), 32'd1);
        end
        chk("rr_seq_data", 32'(m), 32'h10);

        m_ready = 1'b0;
        #1;
        chk("stall_ready", 32'(x_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ch", 32'(m_ch), 32'd0);
            chk("stall_m", 32'(m), 32'h10);
            chk("stall_ready_hold", 32'(x_ready), 32'd0);
        end
        m_ready = 1'b1;
        #1;
        chk("resume_ready", 32'(x_ready), 32'b0010);
        tick();
        chk("resume_ch", 32'(m_ch), 32'd1);
        chk("resume_m", 32'(m), 32'h21);

        mode    = 1'b0;
        sel     = 2'd1;
        x_valid = 4'b1000;
        #1;
        chk("fix_nogrant_ready", 32'(x_ready), 32'd0);
        tick();
        chk("fix_drain_valid", 32'(m_valid), 32'd0);

        sel      = 2'd2;
        x_valid  = 4'b0100;
        x[23:16] = 8'hA5;
        #1;
        chk("fix_sel2_ready", 32'(x_ready), 32'b0100);
        tick();
        chk("fix_sel2_m", 32'(m), 32'hA5);
        chk("fix_sel2_ch", 32'(m_ch), 32'd2);
        chk("fix_sel2_valid", 32'(m_valid), 32'd1);

        for (int i = 0; i < 300; i++) begin
            x       = $urandom;
            x_valid = 4'($urandom);
            sel     = 2'($urandom);
            mode    = 1'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        mode    = 1'b1;
        x_valid = 4'b1111;
        m_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(m_valid), 32'd0);
        chk("async_rst_ready", 32'(x_ready), 32'd0);
        chk("async_rst_m", 32'(m), 32'd0);
        tick();
        rst     = 1'b0;
        x_valid = 4'b1010;
        x       = {8'h99, 8'h88, 8'h77, 8'h66};
        #1;
        chk("post_rst_ready", 32'(x_ready), 32'b0010);
        tick();
        chk("post_rst_ch", 32'(m_ch), 32'd1);
        chk("post_rst_m", 32'(m), 32'h77);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels; SHALL be >= 2.
REQ-002 Parameter DATA_W, default 8: width of each channel's data.
REQ-003 Derived constant SEL_W = clog2(NUM_CH): width of sel and m_ch.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 x  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 x_valid  input  NUM_CH  per-channel valid.
REQ-008 x_ready  output  NUM_CH  per-channel ready.
REQ-009 sel  input  SEL_W  channel select, used in fixed mode only.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 m  output  DATA_W  registered selected data.
REQ-012 m_valid  output  1  m holds a valid word.
REQ-013 m_ready  input  1  downstream accepts m.
REQ-014 m_ch  output  SEL_W  index of the channel that supplied m.

Function
REQ-015 A transfer on channel i SHALL occur when x_valid[i] and x_ready[i] are both 1 at a rising clk edge.
REQ-016 The output slot SHALL have two states: EMPTY (m_valid=0) and FULL (m_valid=1).
REQ-017 load_en SHALL be 1 when the slot is EMPTY, or when it is FULL and m_ready=1.
REQ-018 At most one x_ready bit SHALL be 1 per cycle; that bit SHALL be the grant channel, and only while load_en=1.
REQ-019 Fixed mode: grant SHALL be sel if x_valid[sel]=1; otherwise there is no grant.
REQ-020 Fixed mode with sel >= NUM_CH: there SHALL be no grant.
REQ-021 Round-robin mode: grant SHALL be the first channel with x_valid=1, searching from ptr+1 upward modulo NUM_CH.
REQ-022 ptr SHALL update to the granted index on each transfer in either mode.
REQ-023 Round-robin mode: ptr SHALL wrap from NUM_CH-1 to 0.
REQ-024 On a transfer, m and m_ch SHALL load the granted data and index at the same edge, and the slot SHALL be FULL next cycle: latency 1 clk.
REQ-025 FULL with m_ready=1 and a grant present: the slot SHALL stay FULL with the new word, sustaining 1 word/clk.
REQ-026 FULL with m_ready=1 and no grant: the slot SHALL go EMPTY.
REQ-027 FULL with m_ready=0: m, m_ch and m_valid SHALL hold stable, and every x_ready bit SHALL be 0.
REQ-028 A change on mode or sel SHALL affect arbitration in the same cycle only; a word already held SHALL be unaffected.
REQ-029 x_ready SHALL NOT depend combinationally on x_valid of non-granted channels.

Reset
REQ-030 While rst=1, m_valid SHALL be 0, m SHALL be 0, m_ch SHALL be 0, ptr SHALL be NUM_CH-1, and every x_ready bit SHALL be 0, regardless of clk.
REQ-031 Asserting rst while the slot is FULL SHALL discard the held word; no partial transfer is reported.
REQ-032 After rst deasserts, the first round-robin search SHALL start at channel 0.

Configuration
REQ-033 Macro MUX_RR_REG_CNT_EN defined: an extra output port cnt (16 bits) SHALL count transfers on m (m_valid and m_ready).
REQ-034 With MUX_RR_REG_CNT_EN defined, cnt SHALL reset to 0 and wrap from 0xFFFF to 0.
REQ-035 Macro MUX_RR_REG_CNT_EN undefined: the cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 Shared package mux_pkg SHALL hold the mode constants MODE_FIXED=0 and MODE_RR=1 and the default NUM_CH/DATA_W values.
REQ-037 The round-robin priority picker SHALL be a sub-module rr_arb (inputs: request vector, ptr; output: grant index and grant-valid).
REQ-038 The output slot and ptr SHALL be the only state in mux_rr_reg.

Verification
REQ-039 Fixed mode, sel=2, x_valid=0100, ch2 data=0xA5, m_ready=1 -> x_ready=0100; next cycle m=0xA5, m_ch=2, m_valid=1.
REQ-040 Round-robin mode, x_valid=1111 held, m_ready=1 -> m_ch sequence 0,1,2,3,0 on consecutive cycles, one word/clk.
REQ-041 Slot FULL, m_ready=0 for 3 cycles with all x_valid=1 -> m and m_ch stable, x_ready=0000; after m_ready=1, the next channel in rotation is granted.
REQ-042 Fixed mode, sel=1, x_valid[1]=0, x_valid[3]=1 -> no grant, and m_valid falls after the held word drains.
REQ-043 rst asserted mid-stream asynchronously, between edges -> m_valid=0 immediately; after release, the first round-robin grant is the lowest valid channel starting at channel 0.
REQ-044 With MUX_RR_REG_CNT_EN defined, 65537 transfers -> cnt=1.
